// File: rtl/vga_pixel_compositor.sv
// vga_pixel_compositor: picks the highest-priority visible layer, blanks outside video, aligns syncs
// through a two-tick pipeline and snapshots per-frame sprite collisions on each vsync falling edge.
module vga_pixel_compositor #(
    parameter int NUM_LAYERS  = 4,
    parameter int COLOR_W     = 24,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                          FPGA_Clock,
    input  logic                          reset,
    input  logic                          pixel_en,
    input  logic                          video_on,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]         layer_visible,
    input  logic [COLOR_W-1:0]            bg_rgb,
    output logic [7:0]                    VGA_R,
    output logic [7:0]                    VGA_G,
    output logic [7:0]                    VGA_B,
    output logic                          VGA_HS,
    output logic                          VGA_VS,
    output logic                          VGA_BLANK_N,
    output logic                          VGA_SYNC_N,
    output logic                          VGA_CLK,
    output logic                          collision_flag,
    output logic [NUM_LAYERS-1:0]         collision_mask,
    output logic [FRAME_CNT_W-1:0]        frame_count
);
    logic [COLOR_W-1:0]     col_d, col1_q, rgb2_q;
    logic                   von1_q, hs1_q, vs1_q, blank2_q, hs2_q, vs2_q;
    logic                   clk_q, vs_prev_q, flag_q, frame_edge;
    logic [NUM_LAYERS-1:0]  contrib, pend_d, pend_q, mask_q;
    logic [FRAME_CNT_W-1:0] fcnt_q;

    // scanning downward lets the lowest visible index overwrite the rest
    always_comb begin
        col_d = bg_rgb;
        for (int k = NUM_LAYERS - 1; k >= 0; k--)
            col_d = layer_visible[k] ? layer_rgb[k*COLOR_W +: COLOR_W] : col_d;
    end

    assign contrib    = (video_on && (layer_visible & (layer_visible - NUM_LAYERS'(1))) != '0) ? layer_visible : '0;
    assign frame_edge = !vsync_in && vs_prev_q;
    assign pend_d     = (frame_edge ? '0 : pend_q) | contrib;

    always_ff @(posedge FPGA_Clock) begin
        if (reset) begin
            col1_q    <= '0;
            von1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            rgb2_q    <= '0;
            blank2_q  <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            clk_q     <= 1'b0;
            vs_prev_q <= 1'b1;
            pend_q    <= '0;
            mask_q    <= '0;
            flag_q    <= 1'b0;
            fcnt_q    <= '0;
        end else if (pixel_en) begin
            col1_q    <= col_d;
            von1_q    <= video_on;
            hs1_q     <= hsync_in;
            vs1_q     <= vsync_in;
            rgb2_q    <= von1_q ? col1_q : '0;
            blank2_q  <= von1_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            clk_q     <= ~clk_q;
            vs_prev_q <= vsync_in;
            pend_q    <= pend_d;
            mask_q    <= frame_edge ? pend_q : mask_q;
            flag_q    <= frame_edge ? (pend_q != '0) : flag_q;
            fcnt_q    <= frame_edge ? fcnt_q + FRAME_CNT_W'(1) : fcnt_q;
        end
    end

    assign VGA_R          = rgb2_q[COLOR_W-1 -: 8];
    assign VGA_G          = rgb2_q[COLOR_W-9 -: 8];
    assign VGA_B          = rgb2_q[7:0];
    assign VGA_HS         = hs2_q;
    assign VGA_VS         = vs2_q;
    assign VGA_BLANK_N    = blank2_q;
    assign VGA_SYNC_N     = 1'b0;
    assign VGA_CLK        = clk_q;
    assign collision_flag = flag_q;
    assign collision_mask = mask_q;
    assign frame_count    = fcnt_q;
endmodule

// File: tb/tb_vga_pixel_compositor.sv
// tb_vga_pixel_compositor: directed and random stimulus checked against a per-tick reference model
// (delay queue for the video path, frame bookkeeping for collisions).
module tb_vga_pixel_compositor;
    localparam int NL = 4;
    localparam int CW = 24;
    localparam int FW = 8;

    logic           clk = 1'b0, reset = 1'b1, pixel_en = 1'b0;
    logic           video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [NL*CW-1:0] layer_rgb = '0;
    logic [NL-1:0]  layer_visible = '0;
    logic [CW-1:0]  bg_rgb = '0;
    logic [7:0]     VGA_R, VGA_G, VGA_B;
    logic           VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, collision_flag;
    logic [NL-1:0]  collision_mask;
    logic [FW-1:0]  frame_count;

    vga_pixel_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .FRAME_CNT_W(FW)) dut (
        .FPGA_Clock(clk), .reset(reset), .pixel_en(pixel_en), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_rgb(layer_rgb),
        .layer_visible(layer_visible), .bg_rgb(bg_rgb),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK),
        .collision_flag(collision_flag), .collision_mask(collision_mask), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] rgb;
        logic        blank;
        logic        hs;
        logic        vs;
    } out_t;

    int            checks = 0, failures = 0;
    out_t          q[$];
    out_t          cur;
    logic [NL-1:0] m_pend, m_mask;
    logic          m_flag, m_prev, m_vclk;
    int            m_fc;

    function automatic out_t ref_pixel();
        out_t o;
        o.rgb   = '0;
        o.blank = video_on;
        o.hs    = hsync_in;
        o.vs    = vsync_in;
        if (video_on) begin
            o.rgb = bg_rgb;
            for (int k = 0; k < NL; k++)
                if (layer_visible[k]) begin
                    o.rgb = layer_rgb[k*CW +: CW];
                    break;
                end
        end
        return o;
    endfunction

    task automatic model_reset();
        cur = {24'h0, 1'b0, 1'b1, 1'b1};
        q.delete();
        q.push_back(cur);
        m_pend = '0;
        m_mask = '0;
        m_flag = 1'b0;
        m_prev = 1'b1;
        m_vclk = 1'b0;
        m_fc   = 0;
    endtask

    task automatic model_tick();
        q.push_back(ref_pixel());
        cur    = q.pop_front();
        m_vclk = ~m_vclk;
        if (!vsync_in && m_prev) begin
            m_mask = m_pend;
            m_flag = (m_pend != '0);
            m_fc   = (m_fc + 1) % (1 << FW);
            m_pend = '0;
        end
        if (video_on && $countones(layer_visible) >= 2) m_pend |= layer_visible;
        m_prev = vsync_in;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("VGA_R", 32'(VGA_R), 32'(cur.rgb[23:16]));
        chk("VGA_G", 32'(VGA_G), 32'(cur.rgb[15:8]));
        chk("VGA_B", 32'(VGA_B), 32'(cur.rgb[7:0]));
        chk("VGA_BLANK_N", 32'(VGA_BLANK_N), 32'(cur.blank));
        chk("VGA_HS", 32'(VGA_HS), 32'(cur.hs));
        chk("VGA_VS", 32'(VGA_VS), 32'(cur.vs));
        chk("VGA_SYNC_N", 32'(VGA_SYNC_N), 32'd0);
        chk("VGA_CLK", 32'(VGA_CLK), 32'(m_vclk));
        chk("collision_flag", 32'(collision_flag), 32'(m_flag));
        chk("collision_mask", 32'(collision_mask), 32'(m_mask));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
    endtask

    task automatic step(input logic pe);
        pixel_en = pe;
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else if (pe) model_tick();
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();
        video_on = 1'b0;
        repeat (3) step(1'b1);
        chk("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("rst_syncs", {30'h0, VGA_HS, VGA_VS}, 32'h3);
        chk("rst_blank", 32'(VGA_BLANK_N), 32'h0);
        chk("rst_fc", 32'(frame_count), 32'h0);

        layer_rgb     = {24'h0000FF, 24'hAAAAAA, 24'h00FF00, 24'hBBBBBB};
        bg_rgb        = 24'h123456;
        layer_visible = 4'b1010;
        video_on      = 1'b1;
        repeat (2) step(1'b1);
        chk("prio_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0000FF00);
        layer_visible = 4'b0000;
        repeat (2) step(1'b1);
        chk("bg_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00123456);
        vsync_in = 1'b0;
        step(1'b1);
        chk("pend_mask", 32'(collision_mask), 32'hA);
        chk("pend_flag", 32'(collision_flag), 32'h1);
        vsync_in = 1'b1;
        step(1'b1);

        video_on = 1'b0;
        hsync_in = 1'b0;
        step(1'b1);
        hsync_in = 1'b1;
        step(1'b0);
        repeat (6) begin
            step(1'b1);
            step(1'b0);
        end
        repeat (10) step(1'b0);

        do_reset();
        video_on      = 1'b1;
        layer_visible = 4'b0101;
        step(1'b1);
        layer_visible = 4'b0001;
        repeat (3) step(1'b1);
        layer_visible = 4'b0000;
        vsync_in      = 1'b0;
        step(1'b1);
        chk("f1_mask", 32'(collision_mask), 32'h5);
        chk("f1_flag", 32'(collision_flag), 32'h1);
        chk("f1_fc", 32'(frame_count), 32'h1);
        vsync_in      = 1'b1;
        layer_visible = 4'b0010;
        repeat (4) step(1'b1);
        vsync_in      = 1'b0;
        step(1'b1);
        chk("f2_mask", 32'(collision_mask), 32'h0);
        chk("f2_flag", 32'(collision_flag), 32'h0);
        chk("f2_fc", 32'(frame_count), 32'h2);
        vsync_in = 1'b1;
        step(1'b1);

        video_on      = 1'b0;
        layer_visible = 4'b0000;
        while (m_fc != (1 << FW) - 1) begin
            vsync_in = 1'b0;
            step(1'b1);
            vsync_in = 1'b1;
            step(1'b1);
        end
        video_on      = 1'b1;
        layer_visible = 4'b0011;
        vsync_in      = 1'b0;
        step(1'b1);
        chk("fc_wrap", 32'(frame_count), 32'h0);
        chk("edge_tick_mask", 32'(collision_mask), 32'h0);
        layer_visible = 4'b0000;
        vsync_in      = 1'b1;
        repeat (3) step(1'b1);
        vsync_in = 1'b0;
        step(1'b1);
        chk("next_frame_mask", 32'(collision_mask), 32'h3);
        vsync_in = 1'b1;
        step(1'b1);

        layer_visible = 4'b1100;
        step(1'b1);
        layer_visible = 4'b0000;
        step(1'b1);
        do_reset();
        repeat (3) step(1'b1);
        vsync_in = 1'b0;
        step(1'b1);
        chk("post_reset_mask", 32'(collision_mask), 32'h0);
        chk("post_reset_flag", 32'(collision_flag), 32'h0);
        chk("post_reset_fc", 32'(frame_count), 32'h1);
        vsync_in = 1'b1;

        repeat (2000) begin
            layer_rgb     = {$urandom, $urandom, $urandom};
            bg_rgb        = CW'($urandom);
            layer_visible = NL'($urandom);
            video_on      = ($urandom_range(0, 3) != 0);
            hsync_in      = ($urandom_range(0, 7) != 0);
            vsync_in      = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_pixel_compositor.md
Name: vga_pixel_compositor

Overview:
- Output stage directly downstream of the sprite renderers. Takes each renderer's 24-bit colour and visible flag, plus a background colour.
- Selects the highest-priority visible layer each pixel and forces black outside the active area.
- Delays the sync signals so they stay aligned with the colour path, then drives the VGA DAC pins.
- Also records per-frame sprite collisions, with a frame counter, for game logic.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 is highest priority.
- COLOR_W, 24, colour width per layer, packed {R[23:16],G[15:8],B[7:0]}.
- FRAME_CNT_W, 16, width of frame counter.

Ports:
- FPGA_Clock  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- pixel_en  input  1  one-cycle pixel tick (25 MHz rate); all pipeline state advances only when 1.
- video_on  input  1  active-area flag from timing generator, aligned with layer inputs.
- hsync_in  input  1  horizontal sync from timing generator, active-low, aligned with layer inputs.
- vsync_in  input  1  vertical sync from timing generator, active-low, aligned with layer inputs.
- layer_rgb  input  NUM_LAYERS*COLOR_W  layer k occupies bits [k*24+23 : k*24].
- layer_visible  input  NUM_LAYERS  visible flag per layer.
- bg_rgb  input  COLOR_W  background colour.
- VGA_R, VGA_G, VGA_B  output  8 each  DAC colour.
- VGA_HS, VGA_VS  output  1 each  delayed syncs, active-low.
- VGA_BLANK_N  output  1  delayed video_on.
- VGA_SYNC_N  output  1  constant 0.
- VGA_CLK  output  1  registered toggle on each pixel_en tick.
- collision_flag  output  1  at least one collision occurred in the last completed frame.
- collision_mask  output  NUM_LAYERS  layers involved in any collision in the last completed frame.
- frame_count  output  FRAME_CNT_W  completed-frame counter, wraps modulo 2^FRAME_CNT_W.

Behaviour:
- One clock domain: FPGA_Clock. Reset is synchronous and active-high.
- Reset values:
  - VGA_R/G/B = 0, VGA_BLANK_N = 0, VGA_HS = 1, VGA_VS = 1, VGA_CLK = 0.
  - collision_flag = 0, collision_mask = 0, frame_count = 0.
  - All pipeline registers cleared (syncs cleared to 1). Pending collision mask = 0. vsync_prev = 1.
- Reset overrides pixel_en.
- When pixel_en = 0, every register holds its value (VGA_CLK included).
- Stage 1, registered on pixel_en:
  - sel = lowest index k with layer_visible[k] = 1; colour1 = layer_rgb[k].
  - If no layer is visible, colour1 = bg_rgb.
  - Register video_on, hsync_in and vsync_in alongside colour1.
- Stage 2, registered on pixel_en:
  - VGA_R/G/B = colour1 when stage-1 video_on = 1, else 0.
  - VGA_BLANK_N, VGA_HS and VGA_VS take their stage-1 values.
- Latency: exactly 2 pixel_en ticks from inputs to all VGA outputs, for colour and syncs alike.
- Collision detection, on each pixel_en tick with video_on = 1:
  - If 2 or more bits of layer_visible are set, pending |= layer_visible.
  - With a single visible layer or video_on = 0, pending is unchanged.
- Frame boundary, on a pixel_en tick where vsync_in = 0 and vsync_prev = 1 (falling edge):
  - collision_mask <= pending; collision_flag <= (pending != 0).
  - frame_count <= frame_count + 1, wrapping from all-ones to 0.
  - pending <= 0, or that tick's contribution if it qualifies; the new frame wins.
- vsync_prev updates on every pixel_en tick.
- Reset mid-frame: pending is discarded. The first snapshot after reset covers only pixels seen after reset.
- Ties and priority are fixed: layer 0 always wins. Background is used only when every visible flag is 0.

Test Plan:
- Reset then 3 pixel_en ticks with video_on = 0 -> VGA_R/G/B = 0, VGA_HS = VGA_VS = 1, BLANK_N = 0, frame_count = 0.
- Layers 1 and 3 visible with colours 0x00FF00 and 0x0000FF, bg = 0x123456, video_on = 1 -> two ticks later VGA_G = 0xFF, VGA_R = VGA_B = 0. Then clear all visible flags -> bg 0x12/0x34/0x56 appears two ticks later. pending = 4'b1010.
- Pulse hsync_in low for 1 tick with pixel_en toggling every 2 clocks -> VGA_HS low for exactly 1 tick, 2 pixel_en ticks later. Hold pixel_en = 0 for 10 clocks -> outputs frozen.
- Frame with one collision between layers 0 and 2, then a vsync falling edge -> collision_mask = 4'b0101, collision_flag = 1, frame_count = 1. Next frame with no collision, then a vsync edge -> mask = 0, flag = 0, frame_count = 2.
- Preload frame_count to all-ones via 65535 frames (or a forced counter) -> the next edge gives frame_count = 0. Collision on the same tick as the vsync edge with video_on = 1 -> counted in the following frame's mask, not the snapshot.
- Assert reset mid-frame after a collision -> the next snapshot shows mask = 0 when no further collisions occur.
